// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port tightly coupled memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } rsp_tag_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Two-way grant selection: round-robin on a last-winner bit, or fixed priority
// with a saturating starvation counter for port 1. Grants are combinational.
import mem_arb_pkg::*;

module mem_arb_sel #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

    localparam logic FIXED = (ARB_MODE == int'(ARB_FIXED));
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic                  last;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  p1_wins;

    // p1_wins only decides contention; a lone requester is always granted.
    always_comb begin
        p1_wins = FIXED ? (wait_cnt == WAIT_LIMIT) : ~last;
        p0_gnt  = rst_ni & p0_req & (~p1_req | ~p1_wins);
        p1_gnt  = rst_ni & p1_req & (~p0_req | p1_wins);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last     <= 1'b1;
            wait_cnt <= '0;
        end else begin
            if (p0_gnt) begin
                last <= 1'b0;
            end else if (p1_gnt) begin
                last <= 1'b1;
            end

            if (p1_gnt || !FIXED) begin
                wait_cnt <= '0;
            end else if (p1_req && (wait_cnt != WAIT_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch (port 0) and LSU (port 1) with
// zero-cycle grant and one rvalid per access exactly MEM_LATENCY cycles later.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ARB_MODE    = 0,
    parameter int MAX_WAIT    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    rsp_tag_t rsp_pipe [MEM_LATENCY];
    rsp_tag_t rsp_out;

    mem_arb_sel #(
        .ARB_MODE (ARB_MODE),
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .p0_req (p0_req_i),
        .p1_req (p1_req_i),
        .p0_gnt (p0_gnt_o),
        .p1_gnt (p1_gnt_o)
    );

    // With no grant the mux rests on port 0.
    assign mem_req_o   = p0_gnt_o | p1_gnt_o;
    assign mem_addr_o  = p1_gnt_o ? p1_addr_i  : p0_addr_i;
    assign mem_we_o    = p1_gnt_o ? p1_we_i    : p0_we_i;
    assign mem_be_o    = p1_gnt_o ? p1_be_i    : p0_be_i;
    assign mem_wdata_o = p1_gnt_o ? p1_wdata_i : p0_wdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                rsp_pipe[i] <= '0;
            end
        end else begin
            rsp_pipe[0] <= '{valid: mem_req_o, owner: p1_gnt_o};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rsp_pipe[i] <= rsp_pipe[i-1];
            end
        end
    end

    assign rsp_out = rsp_pipe[MEM_LATENCY-1];

    // Responses already in flight when reset asserts must never surface.
    assign p0_rvalid_o = rst_ni & rsp_out.valid & ~rsp_out.owner;
    assign p1_rvalid_o = rst_ni & rsp_out.valid &  rsp_out.owner;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

endmodule
